// File: rtl/seq_fir_filter_pkg.sv
// Shared types for the sequential FIR filter: controller states and accumulator sizing.
package seq_fir_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_t;

  // Worst-case sum of TAPS full-scale products fits without wrap.
  function automatic int fir_acc_width(input int n, input int taps);
    return 2 * n + $clog2(taps);
  endfunction

endpackage

// File: rtl/seq_fir_filter_if.sv
// Sample/coefficient/result bundle of the sequential FIR filter.
interface seq_fir_filter_if #(
  parameter int N    = 16,
  parameter int TAPS = 8
);
  localparam int AW = $clog2(TAPS);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [N-1:0]  x_in;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [N-1:0]  coef_data;
  logic                 out_valid;
  logic signed [N-1:0]  y_out;
  logic                 sat;

  modport master (
    output in_valid, x_in, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, y_out, sat
  );

  modport slave (
    input  in_valid, x_in, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, y_out, sat
  );

endinterface

// File: rtl/seq_fir_filter_mac_unit.sv
// Single multiplier/accumulator for the FIR taps plus final shift and wrap/clamp.
// Clamping is enabled by defining FIR_SATURATE_EN; otherwise the result wraps.
module fir_mac_unit
  import seq_fir_filter_pkg::*;
#(
  parameter int N     = 16,
  parameter int TAPS  = 8,
  parameter int SHIFT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic signed [N-1:0] h_tap,
  input  logic signed [N-1:0] x_tap,
  output logic signed [N-1:0] y_res,
  output logic                sat_res
);
  localparam int ACC_W = fir_acc_width(N, TAPS);

  logic signed [2*N-1:0]   prod_p0;
  logic signed [ACC_W-1:0] prod_ext_p0;
  logic signed [ACC_W-1:0] acc_nxt_p0;
  logic signed [ACC_W-1:0] acc_p1;

`ifdef FIR_SATURATE_EN
  // Arithmetic shift (truncating toward -inf), then clamp to the N-bit range.
  function automatic logic [N:0] shape_res(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sh;
    sh = v >>> SHIFT;
    if (sh[ACC_W-1:N-1] == {(ACC_W-N+1){sh[ACC_W-1]}})
      return {1'b0, sh[N-1:0]};
    else if (sh[ACC_W-1])
      return {1'b1, 1'b1, {(N-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(N-1){1'b1}}};
  endfunction
`else
  // Low N bits of the shifted accumulator, no clamp.
  function automatic logic [N:0] shape_res(input logic [N-1:0] v);
    return {1'b0, v};
  endfunction
`endif

  // Stage p0: product of the current tap, sign-extended into the accumulator
  assign prod_p0     = h_tap * x_tap;
  assign prod_ext_p0 = {{(ACC_W-2*N){prod_p0[2*N-1]}}, prod_p0};
  assign acc_nxt_p0  = acc_p1 + prod_ext_p0;

`ifdef FIR_SATURATE_EN
  assign {sat_res, y_res} = shape_res(acc_nxt_p0);
`else
  assign {sat_res, y_res} = shape_res(acc_nxt_p0[SHIFT +: N]);
`endif

  // Stage p1: running sum
  always_ff @(posedge clk) begin
    if (rst || clr)
      acc_p1 <= '0;
    else if (en)
      acc_p1 <= acc_nxt_p0;
  end

endmodule

// File: rtl/seq_fir_filter.sv
// Sequential FIR filter: one tap per cycle through a shared MAC, IDLE/MAC/OUT controller.
// Define FIR_SATURATE_EN to clamp results (sat flag); default build wraps.
module seq_fir_filter
  import seq_fir_filter_pkg::*;
#(
  parameter int N     = 16,
  parameter int TAPS  = 8,
  parameter int SHIFT = 4
) (
  input logic              clk,
  input logic              rst,
  seq_fir_filter_if.slave  bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int DEPTH = 1 << AW;

  fir_state_t          state, state_nxt;
  logic [AW-1:0]       cnt;
  logic signed [N-1:0] x_dl [TAPS];
  // Coefficient store is padded to the address space so every address is writable.
  logic signed [N-1:0] coef [DEPTH];
  logic signed [N-1:0] y_q;
  logic                sat_q;
  logic signed [N-1:0] y_res;
  logic                sat_res;
  logic                accept;
  logic                last_tap;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == OUT) && !rst;
  assign bus.y_out     = y_q;
  assign bus.sat       = sat_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_tap = (state == MAC) && (cnt == AW'(TAPS - 1));

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = OUT;
      OUT:                   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x_dl[k] <= '0;
      for (int k = 0; k < DEPTH; k++) coef[k] <= '0;
      cnt   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.coef_we)
        coef[bus.coef_addr] <= bus.coef_data;
      if (accept) begin
        x_dl[0] <= bus.x_in;
        for (int k = 1; k < TAPS; k++) x_dl[k] <= x_dl[k-1];
        cnt <= '0;
      end else if (state == MAC) begin
        cnt <= cnt + AW'(1);
      end
      // Final tap's product is folded in combinationally so y_out is ready in OUT.
      if (last_tap) begin
        y_q   <= y_res;
        sat_q <= sat_res;
      end
    end
  end

  fir_mac_unit #(
    .N     (N),
    .TAPS  (TAPS),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state == MAC),
    .h_tap   (coef[cnt]),
    .x_tap   (x_dl[cnt]),
    .y_res   (y_res),
    .sat_res (sat_res)
  );

endmodule

// File: tb/tb_seq_fir_filter.sv
// Directed bench for seq_fir_filter (N=16, TAPS=8, SHIFT=4); honours FIR_SATURATE_EN.
module tb_seq_fir_filter;
  localparam int N     = 16;
  localparam int TAPS  = 8;
  localparam int SHIFT = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [15:0] y_cap;
  logic        s_cap;
  logic        ok_cap;
  logic        seen;

  seq_fir_filter_if #(.N(N), .TAPS(TAPS)) bus ();

  seq_fir_filter #(.N(N), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [15:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr;
    bus.coef_data = data;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic wait_out(output logic [15:0] y, output logic s, output logic ok);
    ok = 1'b0;
    y  = '0;
    s  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        y  = bus.y_out;
        s  = bus.sat;
        break;
      end
    end
    tick();
  endtask

  task automatic send_get(input logic [15:0] x, output logic [15:0] y, output logic s,
                          output logic ok);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    tick();
    bus.in_valid = 1'b0;
    wait_out(y, s, ok);
  endtask

  task automatic check_res(input string tag, input logic [15:0] y, input logic s, input logic ok,
                           input logic [15:0] ey, input logic es);
    check({tag, " out_valid seen"}, {15'b0, ok}, 16'd1);
    check({tag, " y_out"}, y, ey);
    check({tag, " sat"}, {15'b0, s}, {15'b0, es});
  endtask

  task automatic run_sample(input string tag, input logic [15:0] x, input logic [15:0] ey,
                            input logic es);
    logic [15:0] y;
    logic        s, ok;
    send_get(x, y, s, ok);
    check_res(tag, y, s, ok, ey, es);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    check("rst in_ready", {15'b0, bus.in_ready}, 16'd0);
    check("rst out_valid", {15'b0, bus.out_valid}, 16'd0);
    check("rst y_out", bus.y_out, 16'h0000);
    check("rst sat", {15'b0, bus.sat}, 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("release in_ready", {15'b0, bus.in_ready}, 16'd1);
    tick();

    for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'(16 * (k + 1)));

    // Impulse with cycle-accurate timing; extra in_valid in cycle 5 must be ignored
    bus.in_valid = 1'b1;
    bus.x_in     = 16'h0001;
    @(negedge clk);
    check("t0 in_ready", {15'b0, bus.in_ready}, 16'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        bus.in_valid = 1'b1;
        bus.x_in     = 16'h0100;
      end
      if (c == 6) bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("t%0d in_ready", c), {15'b0, bus.in_ready}, (c == 10) ? 16'd1 : 16'd0);
      check($sformatf("t%0d out_valid", c), {15'b0, bus.out_valid}, (c == 9) ? 16'd1 : 16'd0);
      if (c == 9) begin
        check("imp0 y_out", bus.y_out, 16'd1);
        check("imp0 sat", {15'b0, bus.sat}, 16'd0);
      end
      tick();
    end
    for (int k = 2; k <= 8; k++) run_sample($sformatf("imp%0d", k - 1), 16'h0000, 16'(k), 1'b0);
    run_sample("imp tail", 16'h0000, 16'h0000, 1'b0);

    // Coefficient write during MAC is ignored
    bus.in_valid = 1'b1;
    bus.x_in     = 16'h0001;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd0;
    bus.coef_data = 16'h0000;
    tick();
    bus.coef_we   = 1'b0;
    wait_out(y_cap, s_cap, ok_cap);
    check_res("busy cur", y_cap, s_cap, ok_cap, 16'd1, 1'b0);
    run_sample("busy next", 16'h0003, 16'd5, 1'b0);

    // Reset in cycle 4 of a computation
    bus.in_valid = 1'b1;
    bus.x_in     = 16'h0005;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst in_ready", {15'b0, bus.in_ready}, 16'd0);
    check("midrst out_valid", {15'b0, bus.out_valid}, 16'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst release in_ready", {15'b0, bus.in_ready}, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst no out_valid", {15'b0, seen}, 16'd0);
    tick();
    for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'(16 * (k + 1)));
    run_sample("post-rst imp0", 16'h0001, 16'd1, 1'b0);
    run_sample("post-rst imp1", 16'h0000, 16'd2, 1'b0);

    // Negative sample passes through unchanged with unity gain
    write_coef(3'd0, 16'd16);
    for (int k = 1; k < TAPS; k++) write_coef(3'(k), 16'h0000);
    run_sample("sign", 16'hFFFB, 16'hFFFB, 1'b0);

    // Coefficient write and accept in the same cycle use the new coefficient
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'd0;
    bus.coef_data = 16'd32;
    bus.in_valid  = 1'b1;
    bus.x_in      = 16'h0003;
    tick();
    bus.coef_we  = 1'b0;
    bus.in_valid = 1'b0;
    wait_out(y_cap, s_cap, ok_cap);
    check_res("same-cycle write", y_cap, s_cap, ok_cap, 16'd6, 1'b0);

    // Shift truncates toward minus infinity: -1 >>> 4 stays -1
    write_coef(3'd0, 16'h0001);
    run_sample("trunc neg", 16'hFFFF, 16'hFFFF, 1'b0);

    // Full-scale overflow
    for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'h7FFF);
    for (int k = 0; k < TAPS - 1; k++) send_get(16'h7FFF, y_cap, s_cap, ok_cap);
`ifdef FIR_SATURATE_EN
    run_sample("overflow", 16'h7FFF, 16'h7FFF, 1'b1);
`else
    run_sample("overflow", 16'h7FFF, 16'h8000, 1'b0);
`endif
    @(negedge clk);
    check("pulse width out_valid", {15'b0, bus.out_valid}, 16'd0);
`ifdef FIR_SATURATE_EN
    check("y_out held", bus.y_out, 16'h7FFF);
`else
    check("y_out held", bus.y_out, 16'h8000);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_fir_filter.md
SEQ_FIR_FILTER -- requirements
Module: seq_fir_filter

Interface
REQ-001 Parameter N, default 16: sample, coefficient and output width, signed two's complement.
REQ-002 Parameter TAPS, default 8: filter length; legal range 2..64.
REQ-003 Parameter SHIFT, default 4: arithmetic right shift applied to the accumulator before output.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  x_in holds a new sample.
REQ-007 in_ready  output  1  block can accept a sample.
REQ-008 x_in  input  N  signed input sample.
REQ-009 coef_we  input  1  coefficient write strobe.
REQ-010 coef_addr  input  clog2(TAPS)  tap index k.
REQ-011 coef_data  input  N  signed coefficient h[k].
REQ-012 out_valid  output  1  one-cycle pulse; y_out is a new result.
REQ-013 y_out  output  N  signed filter result, held until the next result.
REQ-014 sat  output  1  last result was clamped; valid with out_valid.

Function
REQ-015 The block SHALL compute y[n] = (sum over k=0..TAPS-1 of h[k]*x[n-k]) >>> SHIFT, where x[n] is the newest sample.
REQ-016 The block SHALL use one multiplier and one accumulator, time-multiplexed over the taps at one tap per cycle.
REQ-017 The FSM SHALL have three states: IDLE, MAC and OUT.
- IDLE -> MAC on accept (in_valid & in_ready).
- MAC lasts exactly TAPS cycles, then moves to OUT.
- OUT lasts 1 cycle, then returns to IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid in any other state SHALL be ignored, with no sample lost or queued.
REQ-019 On accept, the block SHALL shift the TAPS-deep delay line (x_in enters position 0, the oldest sample is dropped) and SHALL clear the accumulator.
REQ-020 Timing: for an accept in cycle 0, MAC SHALL occupy cycles 1..TAPS, out_valid=1 and y_out updated in cycle TAPS+1, and in_ready=1 again in cycle TAPS+2.
REQ-021 The accumulator SHALL be 2N+clog2(TAPS) bits wide, so internal overflow is impossible; the shift SHALL be arithmetic and SHALL truncate.
REQ-022 A coefficient write in IDLE SHALL update h[coef_addr] at that edge; writes in MAC or OUT SHALL be ignored.
REQ-023 If coef_we and an accept occur in the same IDLE cycle, the computation SHALL use the newly written coefficient.

Reset
REQ-024 rst SHALL force state IDLE and zero the delay line, coefficients, accumulator and y_out; out_valid=0, sat=0.
REQ-025 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-026 rst asserted during MAC or OUT SHALL abort the computation with no out_valid pulse.

Configuration
REQ-027 With FIR_SATURATE_EN defined, the shifted result SHALL be clamped to [-2^(N-1), 2^(N-1)-1] and sat SHALL be 1 when clamped.
REQ-028 Without FIR_SATURATE_EN, the low N bits SHALL be output unchanged (wrap) and sat SHALL be tied 0.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/MAC/OUT) and the accumulator-width function.
REQ-030 One sub-module, fir_mac_unit, SHALL implement the signed multiply-accumulate and the final shift/clamp.

Verification (N=16, TAPS=8, SHIFT=4)
REQ-031 Impulse: h[k]=16*(k+1), feed x=1 then seven 0s -> y_out sequence 1,2,3,4,5,6,7,8, then 0.
REQ-032 Timing: accept in cycle 0 -> out_valid only in cycle 9, in_ready low in cycles 1..9, and an in_valid offered in cycle 5 is not consumed.
REQ-033 Sign: h[0]=16, all other h=0, x=0xFFFB -> y_out=0xFFFB, sat=0.
REQ-034 Overflow: all h=0x7FFF, eight samples of 0x7FFF -> with macro y_out=0x7FFF, sat=1; without macro y_out=0x8000, sat=0.
REQ-035 Reset mid-MAC: rst in cycle 4 -> no out_valid pulse, in_ready=1 after release, next impulse response starts from a zeroed delay line.
REQ-036 Busy write: coef_we with h[0]=0 during MAC -> ignored, and the next result still uses the old h[0].
